// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter with a small input FIFO. Upstream logic pushes words
// through a valid/ready handshake. The transmitter pops them and serialises
// each one as a frame: a start bit, the data bits LSB first, an optional
// parity bit, then one or two stop bits. When another word is waiting at the
// end of a frame, the next frame follows with no idle gap.
//
// Parameters
//   DATA_BITS     data bits per frame, 5..9
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     stop bits per frame, 1 or 2
//   CLKS_PER_BIT  uart_clk_tx cycles per bit, >= 1
//   FIFO_DEPTH    input FIFO entries, a power of 2 and >= 2
//
// Ports
//   uart_clk_tx   in   baud clock; all logic runs on its rising edge
//   RST_n         in   synchronous active-low reset
//   tx_data       in   word to transmit, captured only on an accepted write
//   tx_valid      in   tx_data is valid
//   tx_ready      out  FIFO has room (fifo_level != FIFO_DEPTH)
//   uart_tx_data  out  registered serial line, idle high
//   uart_busy     out  high while a frame is on the line
//   tx_done       out  high during the final cycle of each frame's last stop bit
//   fifo_level    out  number of words currently stored
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          uart_clk_tx,
    input  logic                          RST_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx_data,
    output logic                          uart_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
        $error("uart_tx_fifo: CLKS_PER_BIT must be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    // ------------------------------------------------------------------
    // Widths and terminal counts
    // ------------------------------------------------------------------
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] LAST_CYC  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level_q;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    // Readiness comes only from the level register, so a pop on the same
    // edge never lets a write into a full FIFO.
    assign tx_ready   = (level_q != FULL_LVL);
    assign fifo_level = level_q;
    assign push       = tx_valid && tx_ready;
    assign head       = mem[rd_ptr];

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    assign head_par = (PARITY == 1) ? ~(^head) : (^head);

    // NOTE: the storage array has no reset; only the pointers and level
    // define which entries are valid, and leaving the array unreset lets it
    // map onto plain RAM cells.
    always_ff @(posedge uart_clk_tx) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // NOTE: every register in a clocked block uses <= so all of them
    // update from the same pre-edge values, regardless of statement order.
    always_ff @(posedge uart_clk_tx) begin
        if (!RST_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cyc_q, cyc_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 line_q, line_d;
    logic                 busy_q, busy_d;
    logic                 bit_end;
    logic                 load;

    // Last cycle of the bit currently on the line.
    assign bit_end = (cyc_q == LAST_CYC);

    // Asserted for exactly the final cycle of the last stop bit.
    assign tx_done = (state_q == STOP) && bit_end && (bit_q == LAST_STOP);

    assign uart_tx_data = line_q;
    assign uart_busy    = busy_q;

    always_ff @(posedge uart_clk_tx) begin
        if (!RST_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
        end
    end

    // The line and busy flag are registered, so each branch sets the value
    // the line must carry during the cycle that follows the edge.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cyc_d   = bit_end ? '0 : cyc_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        line_d  = line_q;
        busy_d  = busy_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                cyc_d  = '0;
                bit_d  = '0;
                line_d = 1'b1;
                busy_d = 1'b0;
                load   = (level_q != '0);
            end

            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    line_d  = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = PARITY_BIT;
                            line_d  = par_q;
                        end else begin
                            state_d = STOP;
                            line_d  = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        line_d  = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end

            PARITY_BIT: begin
                if (bit_end) begin
                    state_d = STOP;
                    bit_d   = '0;
                    line_d  = 1'b1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d = '0;
                        if (level_q != '0) begin
                            // Chain straight into the next frame.
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            line_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cyc_d   = '0;
                bit_d   = '0;
                line_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Start a frame from the FIFO head: the start bit goes on the line
        // at this same edge.
        if (load) begin
            state_d = START;
            cyc_d   = '0;
            bit_d   = '0;
            shift_d = head;
            par_d   = head_par;
            line_d  = 1'b0;
            busy_d  = 1'b1;
        end
    end

    assign pop = load;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Four instances of uart_tx_fifo with different frame formats share a clock
// and reset. A frame-level reference model turns every accepted word into
// the list of line values it must produce, placed on an absolute cycle
// timeline; each cycle every output of every instance is compared with that
// timeline. Directed steps follow the test plan, with a random phase between.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int N_DUT = 4;
    localparam int MAXC  = 4096;
    localparam int DEPTH = 4;

    logic uart_clk_tx = 1'b0;
    always #5 uart_clk_tx = ~uart_clk_tx;

    logic       RST_n;
    logic       valid_in [N_DUT];
    logic [7:0] data_in  [N_DUT];
    logic       ready_o  [N_DUT];
    logic       line_o   [N_DUT];
    logic       busy_o   [N_DUT];
    logic       done_o   [N_DUT];
    logic [2:0] level_o  [N_DUT];

    // 0: defaults (8N1, 1 clk/bit)
    uart_tx_fifo u_dut0 (
        .uart_clk_tx(uart_clk_tx), .RST_n(RST_n),
        .tx_data(data_in[0]), .tx_valid(valid_in[0]), .tx_ready(ready_o[0]),
        .uart_tx_data(line_o[0]), .uart_busy(busy_o[0]), .tx_done(done_o[0]),
        .fifo_level(level_o[0]));

    // 1: 7 data bits, even parity
    uart_tx_fifo #(.DATA_BITS(7), .PARITY(2)) u_dut1 (
        .uart_clk_tx(uart_clk_tx), .RST_n(RST_n),
        .tx_data(data_in[1][6:0]), .tx_valid(valid_in[1]), .tx_ready(ready_o[1]),
        .uart_tx_data(line_o[1]), .uart_busy(busy_o[1]), .tx_done(done_o[1]),
        .fifo_level(level_o[1]));

    // 2: 7 data bits, odd parity
    uart_tx_fifo #(.DATA_BITS(7), .PARITY(1)) u_dut2 (
        .uart_clk_tx(uart_clk_tx), .RST_n(RST_n),
        .tx_data(data_in[2][6:0]), .tx_valid(valid_in[2]), .tx_ready(ready_o[2]),
        .uart_tx_data(line_o[2]), .uart_busy(busy_o[2]), .tx_done(done_o[2]),
        .fifo_level(level_o[2]));

    // 3: 4 clocks per bit, 2 stop bits
    uart_tx_fifo #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut3 (
        .uart_clk_tx(uart_clk_tx), .RST_n(RST_n),
        .tx_data(data_in[3]), .tx_valid(valid_in[3]), .tx_ready(ready_o[3]),
        .uart_tx_data(line_o[3]), .uart_busy(busy_o[3]), .tx_done(done_o[3]),
        .fifo_level(level_o[3]));

    function automatic int cfg_db(input int i);
        return (i == 1 || i == 2) ? 7 : 8;
    endfunction
    function automatic int cfg_par(input int i);
        return (i == 1) ? 2 : (i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_sb(input int i);
        return (i == 3) ? 2 : 1;
    endfunction
    function automatic int cfg_cpb(input int i);
        return (i == 3) ? 4 : 1;
    endfunction

    // Reference timeline: expected outputs for the cycle starting at edge e.
    logic exp_line [N_DUT][MAXC];
    logic exp_busy [N_DUT][MAXC];
    logic exp_done [N_DUT][MAXC];
    logic pop_at   [N_DUT][MAXC];
    int   lvl        [N_DUT];
    int   busy_until [N_DUT];

    int cyc;
    int n_checks;
    int n_pass;
    int n_fail;
    int done_cnt [N_DUT];
    int busy_cnt [N_DUT];
    int low_cnt  [N_DUT];

    task automatic check(input string tag, input int i,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s dut%0d cycle %0d: observed %0h expected %0h",
                   tag, i, cyc, obs, exp);
        end
    endtask

    task automatic put_bit(input int i, inout int p, input logic v);
        for (int c = 0; c < cfg_cpb(i); c++) begin
            if (p < MAXC) exp_line[i][p] = v;
            p++;
        end
    endtask

    // Lay one frame onto the timeline beginning at edge 'start'.
    task automatic schedule(input int i, input int start, input logic [7:0] d);
        int p;
        int ones;
        p    = start;
        ones = 0;
        put_bit(i, p, 1'b0);
        for (int b = 0; b < cfg_db(i); b++) begin
            put_bit(i, p, d[b]);
            ones += int'(d[b]);
        end
        if (cfg_par(i) == 2) put_bit(i, p, (ones % 2) == 1);
        if (cfg_par(i) == 1) put_bit(i, p, (ones % 2) == 0);
        for (int s = 0; s < cfg_sb(i); s++) put_bit(i, p, 1'b1);
        for (int k = start; k < p && k < MAXC; k++) exp_busy[i][k] = 1'b1;
        if (p - 1 < MAXC) exp_done[i][p-1] = 1'b1;
        if (start < MAXC) pop_at[i][start] = 1'b1;
        busy_until[i] = p;
    endtask

    // Apply the handshake and reset rules for edge e.
    task automatic model_edge(input int i, input int e);
        bit ready_before;
        bit popped;
        bit acc;
        int start;
        if (!RST_n) begin
            lvl[i]        = 0;
            busy_until[i] = 0;
            for (int k = e; k < MAXC; k++) begin
                exp_line[i][k] = 1'b1;
                exp_busy[i][k] = 1'b0;
                exp_done[i][k] = 1'b0;
                pop_at[i][k]   = 1'b0;
            end
            return;
        end
        ready_before = (lvl[i] != DEPTH);
        popped       = pop_at[i][e];
        acc          = valid_in[i] && ready_before;
        if (acc) begin
            start = (busy_until[i] > e) ? busy_until[i] : e + 1;
            schedule(i, start, data_in[i]);
        end
        lvl[i] = lvl[i] + int'(acc) - int'(popped);
    endtask

    // One clock: model the edge, then compare all outputs mid-cycle.
    task automatic step();
        int e;
        @(posedge uart_clk_tx);
        e = cyc;
        for (int i = 0; i < N_DUT; i++) model_edge(i, e);
        cyc++;
        @(negedge uart_clk_tx);
        for (int i = 0; i < N_DUT; i++) begin
            check("line",  i, 32'(line_o[i]),  32'(exp_line[i][e]));
            check("busy",  i, 32'(busy_o[i]),  32'(exp_busy[i][e]));
            check("done",  i, 32'(done_o[i]),  32'(exp_done[i][e]));
            check("level", i, 32'(level_o[i]), 32'(lvl[i]));
            check("ready", i, 32'(ready_o[i]), 32'(lvl[i] != DEPTH));
            done_cnt[i] += int'(done_o[i] === 1'b1);
            busy_cnt[i] += int'(busy_o[i] === 1'b1);
            low_cnt[i]  += int'(line_o[i] === 1'b0);
        end
        if (cyc >= MAXC - 8) begin
            $display("FAIL cycle_budget: reached %0d cycles, limit %0d", cyc, MAXC - 8);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N_DUT; i++) begin
            done_cnt[i] = 0;
            busy_cnt[i] = 0;
            low_cnt[i]  = 0;
        end
    endtask

    initial begin
        int w;
        int guard;
        bit acc_now;

        cyc      = 0;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        for (int i = 0; i < N_DUT; i++) begin
            lvl[i]        = 0;
            busy_until[i] = 0;
            valid_in[i]   = 1'b0;
            data_in[i]    = 8'h00;
            for (int k = 0; k < MAXC; k++) begin
                exp_line[i][k] = 1'b1;
                exp_busy[i][k] = 1'b0;
                exp_done[i][k] = 1'b0;
                pop_at[i][k]   = 1'b0;
            end
        end
        clear_counts();

        // Reset for three cycles.
        RST_n = 1'b0;
        repeat (3) step();
        RST_n = 1'b1;
        step();

        // Single isolated frame on every instance.
        clear_counts();
        data_in[0] = 8'hA5;
        data_in[1] = 8'h55;
        data_in[2] = 8'h55;
        data_in[3] = 8'h00;
        for (int i = 0; i < N_DUT; i++) valid_in[i] = 1'b1;
        step();
        for (int i = 0; i < N_DUT; i++) valid_in[i] = 1'b0;
        repeat (60) step();
        check("single_done_count", 0, 32'(done_cnt[0]), 32'd1);
        check("single_busy_cycles", 0, 32'(busy_cnt[0]), 32'd10);
        check("even_par_busy_cycles", 1, 32'(busy_cnt[1]), 32'd10);
        check("odd_par_busy_cycles", 2, 32'(busy_cnt[2]), 32'd10);
        check("slow_busy_cycles", 3, 32'(busy_cnt[3]), 32'd44);
        check("slow_low_cycles", 3, 32'(low_cnt[3]), 32'd36);

        // Burst of eight words held valid on instance 0.
        clear_counts();
        w           = 1;
        guard       = 0;
        data_in[0]  = 8'(w);
        valid_in[0] = 1'b1;
        while (w <= 8 && guard < 200) begin
            acc_now = (lvl[0] != DEPTH);
            step();
            if (acc_now) begin
                w++;
                data_in[0] = 8'(w);
            end
            guard++;
        end
        valid_in[0] = 1'b0;
        check("burst_accept_all", 0, 32'(w), 32'd9);
        repeat (100) step();
        check("burst_done_count", 0, 32'(done_cnt[0]), 32'd8);
        check("burst_busy_cycles", 0, 32'(busy_cnt[0]), 32'd80);

        // Random traffic on all instances, then drain.
        repeat (300) begin
            for (int i = 0; i < N_DUT; i++) begin
                valid_in[i] = ($urandom_range(0, 3) == 0);
                data_in[i]  = 8'($urandom);
            end
            step();
        end
        for (int i = 0; i < N_DUT; i++) valid_in[i] = 1'b0;
        repeat (250) step();

        // Reset during data bit 3 of the first of two queued frames.
        clear_counts();
        data_in[0]  = 8'hFF;
        valid_in[0] = 1'b1;
        step();
        data_in[0]  = 8'h0F;
        step();
        valid_in[0] = 1'b0;
        repeat (4) step();
        RST_n = 1'b0;
        step();
        check("midframe_rst_line", 0, 32'(line_o[0]), 32'd1);
        check("midframe_rst_level", 0, 32'(level_o[0]), 32'd0);
        RST_n = 1'b1;
        repeat (60) step();
        check("midframe_rst_no_done", 0, 32'(done_cnt[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
